// File: rtl/mcp4922_frame_rx.sv
// MCP4922 frame receiver: oversamples the DAC's 3-wire bus in the clk domain
// and decodes 16-bit frames into per-channel value/config registers.
//
// Ports:
//   clk, reset        system clock, synchronous active-high reset
//   cs_pin            chip select (active low, async)
//   clk_pin           serial clock, data taken on its rising edge
//   data_pin          serial data, MSB first
//   value_a/value_b   last committed value for channel A/B
//   cfg_a/cfg_b       {BUF, GA_n, SHDN_n} of last frame for channel A/B
//   update            1-cycle pulse on frame commit
//   upd_axis          channel of last committed frame
//   frame_err         1-cycle pulse when a frame ends with bad bit count
//   frame_count       count of committed frames (wraps)
module mcp4922_frame_rx #(
  parameter int SYNC_STAGES = 2,
  parameter int VALUE_BITS  = 12
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cs_pin,
  input  logic                  clk_pin,
  input  logic                  data_pin,
  output logic [VALUE_BITS-1:0] value_a,
  output logic [VALUE_BITS-1:0] value_b,
  output logic [2:0]            cfg_a,
  output logic [2:0]            cfg_b,
  output logic                  update,
  output logic                  upd_axis,
  output logic                  frame_err,
  output logic [15:0]           frame_count
);

  localparam int FB = VALUE_BITS + 4;
  localparam int CW = $clog2(FB + 2);
  localparam logic [CW-1:0] CNT_FULL = CW'(FB);
  localparam logic [CW-1:0] CNT_OVR  = CW'(FB + 1);

  typedef enum logic {
    S_IDLE,
    S_SHIFT
  } state_t;

  // synchronizers plus one extra copy per pin
  logic [SYNC_STAGES-1:0] cs_sq;
  logic [SYNC_STAGES-1:0] ck_sq;
  logic [SYNC_STAGES-1:0] dt_sq;
  logic                   cs_xq;
  logic                   ck_xq;
  logic                   dt_xq;

  // vld_q fills with ones after reset; once full the cs
  // copies reflect real pin samples rather than presets
  logic [SYNC_STAGES:0]   vld_q;
  logic                   armed_q;
  logic                   arm;

  logic                   cs_rise_q;
  logic                   cs_fall_q;
  logic                   ck_rise_q;

  state_t                 state_q, state_d;
  logic [FB-1:0]          shift_q, shift_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   commit_q, commit_d;
  logic                   err_q, err_d;

  logic [VALUE_BITS-1:0]  value_a_q;
  logic [VALUE_BITS-1:0]  value_b_q;
  logic [2:0]             cfg_a_q;
  logic [2:0]             cfg_b_q;
  logic                   update_q;
  logic                   upd_axis_q;
  logic                   frame_err_q;
  logic [15:0]            frame_count_q;

  logic                   cs_s;
  logic                   ck_s;

  assign cs_s = cs_sq[SYNC_STAGES-1];
  assign ck_s = ck_sq[SYNC_STAGES-1];

  // a cs fall only counts after cs has really been seen high,
  // so a reset taken mid-frame cannot start a bogus frame
  assign arm = armed_q | (vld_q[SYNC_STAGES] & cs_xq);

  always_ff @(posedge clk) begin
    if (reset) begin
      cs_sq     <= '1;
      ck_sq     <= '0;
      dt_sq     <= '0;
      cs_xq     <= 1'b1;
      ck_xq     <= 1'b0;
      dt_xq     <= 1'b0;
      vld_q     <= '0;
      armed_q   <= 1'b0;
      cs_rise_q <= 1'b0;
      cs_fall_q <= 1'b0;
      ck_rise_q <= 1'b0;
    end else begin
      cs_sq     <= {cs_sq[SYNC_STAGES-2:0], cs_pin};
      ck_sq     <= {ck_sq[SYNC_STAGES-2:0], clk_pin};
      dt_sq     <= {dt_sq[SYNC_STAGES-2:0], data_pin};
      cs_xq     <= cs_s;
      ck_xq     <= ck_s;
      dt_xq     <= dt_sq[SYNC_STAGES-1];
      vld_q     <= {vld_q[SYNC_STAGES-1:0], 1'b1};
      armed_q   <= arm;
      // edges are registered, so they line up with the x copies
      cs_rise_q <= cs_s & ~cs_xq;
      cs_fall_q <= cs_xq & ~cs_s & arm;
      ck_rise_q <= ck_s & ~ck_xq;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      shift_q  <= '0;
      cnt_q    <= '0;
      commit_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      shift_q  <= shift_d;
      cnt_q    <= cnt_d;
      commit_q <= commit_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    shift_d  = shift_q;
    cnt_d    = cnt_q;
    commit_d = 1'b0;
    err_d    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (cs_fall_q) begin
          state_d = S_SHIFT;
          shift_d = '0;
          cnt_d   = '0;
        end
      end
      S_SHIFT: begin
        if (cs_rise_q) begin
          state_d = S_IDLE;
          if (cnt_q == CNT_FULL) begin
            commit_d = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end else if (ck_rise_q && !cs_xq) begin
          shift_d = {shift_q[FB-2:0], dt_xq};
          if (cnt_q != CNT_OVR) begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // shift_q is only cleared on the cycle after commit_q at the
  // earliest, so it still holds the frame here
  always_ff @(posedge clk) begin
    if (reset) begin
      value_a_q     <= '0;
      value_b_q     <= '0;
      cfg_a_q       <= '0;
      cfg_b_q       <= '0;
      update_q      <= 1'b0;
      upd_axis_q    <= 1'b0;
      frame_err_q   <= 1'b0;
      frame_count_q <= '0;
    end else begin
      update_q    <= commit_q;
      frame_err_q <= err_q;
      if (commit_q) begin
        upd_axis_q    <= shift_q[FB-1];
        frame_count_q <= frame_count_q + 16'd1;
        if (shift_q[FB-1]) begin
          value_b_q <= shift_q[VALUE_BITS-1:0];
          cfg_b_q   <= shift_q[FB-2:FB-4];
        end else begin
          value_a_q <= shift_q[VALUE_BITS-1:0];
          cfg_a_q   <= shift_q[FB-2:FB-4];
        end
      end
    end
  end

  assign value_a     = value_a_q;
  assign value_b     = value_b_q;
  assign cfg_a       = cfg_a_q;
  assign cfg_b       = cfg_b_q;
  assign update      = update_q;
  assign upd_axis    = upd_axis_q;
  assign frame_err   = frame_err_q;
  assign frame_count = frame_count_q;

endmodule

// File: tb/tb_mcp4922_frame_rx.sv
// Testbench for mcp4922_frame_rx: drives DAC bus frames and checks decoded
// outputs through an expectation queue popped by a monitor.
module tb_mcp4922_frame_rx;

  logic        clk;
  logic        reset;
  logic        cs_pin;
  logic        clk_pin;
  logic        data_pin;
  logic [11:0] value_a;
  logic [11:0] value_b;
  logic [2:0]  cfg_a;
  logic [2:0]  cfg_b;
  logic        update;
  logic        upd_axis;
  logic        frame_err;
  logic [15:0] frame_count;

  mcp4922_frame_rx #(
    .SYNC_STAGES(2),
    .VALUE_BITS (12)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .cs_pin     (cs_pin),
    .clk_pin    (clk_pin),
    .data_pin   (data_pin),
    .value_a    (value_a),
    .value_b    (value_b),
    .cfg_a      (cfg_a),
    .cfg_b      (cfg_b),
    .update     (update),
    .upd_axis   (upd_axis),
    .frame_err  (frame_err),
    .frame_count(frame_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit          upd;
    logic [11:0] va;
    logic [11:0] vb;
    logic [2:0]  ca;
    logic [2:0]  cb;
    logic        ax;
    logic [15:0] cnt;
    int          cyc;
  } exp_t;

  exp_t q[$];

  // reference state: what the outputs should hold
  logic [11:0] m_va, m_vb;
  logic [2:0]  m_ca, m_cb;
  logic        m_ax;
  logic [15:0] m_cnt;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)",
               nm, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_va  = '0;
    m_vb  = '0;
    m_ca  = '0;
    m_cb  = '0;
    m_ax  = 1'b0;
    m_cnt = '0;
  endtask

  // a frame is good only with exactly 16 clocks; word layout is
  // {axis, cfg[2:0], value[11:0]}
  task automatic expect_frame(input logic [15:0] w, input int n);
    exp_t e;
    if (n == 16) begin
      m_ax  = w[15];
      m_cnt = m_cnt + 16'd1;
      if (w[15]) begin
        m_cb = w[14:12];
        m_vb = w[11:0];
      end else begin
        m_ca = w[14:12];
        m_va = w[11:0];
      end
      e.upd = 1'b1;
    end else begin
      e.upd = 1'b0;
    end
    e.va  = m_va;
    e.vb  = m_vb;
    e.ca  = m_ca;
    e.cb  = m_cb;
    e.ax  = m_ax;
    e.cnt = m_cnt;
    // cs driven now, sampled next edge, response 4 edges later
    e.cyc = cyc + 5;
    q.push_back(e);
  endtask

  task automatic clock_bits(input logic [15:0] w, input int lo,
                            input int hi, input int hp);
    for (int i = lo; i < hi; i++) begin
      data_pin = (i < 16) ? w[15-i] : 1'($urandom);
      clk_pin  = 1'b0;
      repeat (hp) @(negedge clk);
      clk_pin  = 1'b1;
      repeat (hp) @(negedge clk);
    end
    clk_pin = 1'b0;
  endtask

  task automatic send(input logic [15:0] w, input int n, input int hp);
    cs_pin = 1'b0;
    @(negedge clk);
    clock_bits(w, 0, n, hp);
    @(negedge clk);
    cs_pin = 1'b1;
    expect_frame(w, n);
  endtask

  task automatic drain();
    for (int i = 0; i < 60 && q.size() != 0; i++) @(negedge clk);
    repeat (3) @(negedge clk);
    chk("queue_drained", q.size(), 0);
  endtask

  task automatic chk_outputs(input string tag);
    chk({tag, "_value_a"}, value_a, m_va);
    chk({tag, "_value_b"}, value_b, m_vb);
    chk({tag, "_cfg_a"}, cfg_a, m_ca);
    chk({tag, "_cfg_b"}, cfg_b, m_cb);
    chk({tag, "_upd_axis"}, upd_axis, m_ax);
    chk({tag, "_frame_count"}, frame_count, m_cnt);
    chk({tag, "_update"}, update, 0);
    chk({tag, "_frame_err"}, frame_err, 0);
  endtask

  // monitor: every update/frame_err must match the next expectation
  exp_t me;
  always @(negedge clk) begin
    if (!reset) begin
      if (update && frame_err) begin
        chk("update_and_err_together", 1, 0);
      end
      if (update || frame_err) begin
        if (q.size() == 0) begin
          chk("unexpected_event", {update, frame_err}, 0);
        end else begin
          me = q.pop_front();
          chk("event_kind_update", update, me.upd);
          chk("event_latency", cyc, me.cyc);
          chk("ev_value_a", value_a, me.va);
          chk("ev_value_b", value_b, me.vb);
          chk("ev_cfg_a", cfg_a, me.ca);
          chk("ev_cfg_b", cfg_b, me.cb);
          chk("ev_upd_axis", upd_axis, me.ax);
          chk("ev_frame_count", frame_count, me.cnt);
        end
      end
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation timed out at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  int n, hp, gap, r;
  logic [15:0] w;

  initial begin
    reset    = 1'b1;
    cs_pin   = 1'b1;
    clk_pin  = 1'b0;
    data_pin = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    chk_outputs("reset");
    reset = 1'b0;
    repeat (6) @(negedge clk);

    // single frame, axis 0, 0xABC
    send(16'h7ABC, 16, 1);
    drain();
    chk_outputs("t1");

    // back-to-back with cs high for one cycle
    send(16'h9001, 16, 1);
    @(negedge clk);
    send(16'h7FFF, 16, 1);
    drain();
    chk_outputs("t2");

    // short and long frames
    repeat (3) @(negedge clk);
    send(16'h1234, 15, 1);
    repeat (4) @(negedge clk);
    send(16'h5678, 17, 1);
    drain();
    chk_outputs("t3");

    // reset after 8 bits, then finish the frame
    repeat (3) @(negedge clk);
    cs_pin = 1'b0;
    @(negedge clk);
    clock_bits(16'hB456, 0, 8, 1);
    reset = 1'b1;
    model_reset();
    repeat (2) @(negedge clk);
    chk_outputs("t4_reset");
    reset = 1'b0;
    clock_bits(16'hB456, 8, 16, 1);
    @(negedge clk);
    cs_pin = 1'b1;
    repeat (12) @(negedge clk);
    chk_outputs("t4_after");
    send(16'h3123, 16, 1);
    drain();
    chk_outputs("t4_next");

    // cs pulse with no clocks, then clocks with cs high
    repeat (3) @(negedge clk);
    send(16'h0000, 0, 1);
    drain();
    for (int i = 0; i < 10; i++) begin
      data_pin = 1'($urandom);
      clk_pin  = 1'b1;
      @(negedge clk);
      clk_pin  = 1'b0;
      @(negedge clk);
    end
    drain();
    chk_outputs("t5");

    // randomized frames
    for (int k = 0; k < 24; k++) begin
      r  = $urandom_range(0, 9);
      n  = (r == 0) ? 15 : (r == 1) ? 17 : (r == 2) ? 0 : 16;
      w  = 16'($urandom);
      hp = $urandom_range(1, 3);
      gap = $urandom_range(1, 4);
      send(w, n, hp);
      repeat (gap) @(negedge clk);
    end
    drain();
    chk_outputs("rand");

    // frame counter wrap
    force dut.frame_count_q = 16'hFFFF;
    @(negedge clk);
    release dut.frame_count_q;
    m_cnt = 16'hFFFF;
    @(negedge clk);
    chk("wrap_preload", frame_count, 16'hFFFF);
    send(16'h8555, 16, 1);
    drain();
    chk_outputs("wrap");

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
